// File: rtl/mic_frame_scheduler.sv
// rtl/mic_frame_scheduler.sv - pairs two mic sample streams into sync/A/B byte frames
module mic_frame_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DEPTH     = 4,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       a_data,
  input  logic             a_valid,
  input  logic [7:0]       b_data,
  input  logic             b_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] drop_count,
  output logic             drop_flag,
  output logic             frame_done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, SEND_A, SEND_B} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_a_q [DEPTH];
  logic [7:0]       mem_a_d [DEPTH];
  logic [7:0]       mem_b_q [DEPTH];
  logic [7:0]       mem_b_d [DEPTH];
  logic [AW:0]      wp_a_q, wp_a_d, rp_a_q, rp_a_d;
  logic [AW:0]      wp_b_q, wp_b_d, rp_b_q, rp_b_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             drop_flag_q, drop_flag_d;
  logic             frame_done_q, frame_done_d;

  logic             a_empty, a_full, b_empty, b_full;
  logic             xfer, a_pop, b_pop, a_push, b_push, a_drop, b_drop;
  logic             a_ne_next, b_ne_next;
  logic [CNT_W:0]   drop_sum;

  assign a_empty = (wp_a_q == rp_a_q);
  assign b_empty = (wp_b_q == rp_b_q);
  assign a_full  = (wp_a_q[AW] != rp_a_q[AW]) && (wp_a_q[AW-1:0] == rp_a_q[AW-1:0]);
  assign b_full  = (wp_b_q[AW] != rp_b_q[AW]) && (wp_b_q[AW-1:0] == rp_b_q[AW-1:0]);

  assign xfer   = tx_valid_q && tx_ready;
  assign a_pop  = xfer && (state_q == SEND_A);
  assign b_pop  = xfer && (state_q == SEND_B);
  // A full FIFO still accepts a sample when its head leaves in the same cycle
  assign a_push = a_valid && (!a_full || a_pop);
  assign b_push = b_valid && (!b_full || b_pop);
  assign a_drop = a_valid && !a_push;
  assign b_drop = b_valid && !b_push;

  always_comb begin
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    wp_a_d  = wp_a_q;
    wp_b_d  = wp_b_q;
    rp_a_d  = rp_a_q;
    rp_b_d  = rp_b_q;

    if (a_push) begin
      mem_a_d[wp_a_q[AW-1:0]] = a_data;
      wp_a_d                  = wp_a_q + (AW+1)'(1);
    end
    if (b_push) begin
      mem_b_d[wp_b_q[AW-1:0]] = b_data;
      wp_b_d                  = wp_b_q + (AW+1)'(1);
    end
    if (a_pop) rp_a_d = rp_a_q + (AW+1)'(1);
    if (b_pop) rp_b_d = rp_b_q + (AW+1)'(1);

    a_ne_next = (wp_a_d != rp_a_d);
    b_ne_next = (wp_b_d != rp_b_d);

    drop_sum     = {1'b0, drop_count_q} + (CNT_W+1)'(a_drop) + (CNT_W+1)'(b_drop);
    drop_count_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    drop_flag_d  = drop_flag_q || a_drop || b_drop;
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE:   if (!a_empty && !b_empty) state_d = SYNC;
      SYNC:   if (xfer) state_d = SEND_A;
      SEND_A: if (xfer) state_d = SEND_B;
      SEND_B: begin
        if (xfer) begin
          frame_done_d = 1'b1;
          state_d      = (a_ne_next && b_ne_next) ? SYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output bytes are precomputed for the next state; heads only move on pops, so they hold while stalled
    tx_valid_d = (state_d != IDLE);
    unique case (state_d)
      SYNC:    tx_data_d = SYNC_BYTE;
      SEND_A:  tx_data_d = mem_a_q[rp_a_d[AW-1:0]];
      SEND_B:  tx_data_d = mem_b_q[rp_b_d[AW-1:0]];
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wp_a_q       <= '0;
      rp_a_q       <= '0;
      wp_b_q       <= '0;
      rp_b_q       <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      drop_count_q <= '0;
      drop_flag_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_a_q       <= wp_a_d;
      rp_a_q       <= rp_a_d;
      wp_b_q       <= wp_b_d;
      rp_b_q       <= rp_b_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      drop_count_q <= drop_count_d;
      drop_flag_q  <= drop_flag_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign drop_count = drop_count_q;
  assign drop_flag  = drop_flag_q;
  assign frame_done = frame_done_q;
endmodule
